// File: rtl/hax_call_scheduler.sv
`default_nettype none
// hax_call_scheduler: latches floor calls and feeds hax_elevator one SCAN-ordered press at a time.
// door_state_i: 1 = OPEN, 0 = CLOSE. Direction encoding: 1 = UP, 0 = DOWN.
module hax_call_scheduler #(
   parameter int NUM_FLOORS   = 8,
   parameter int DWELL_CYCLES = 4,
   parameter int FLOOR_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  call_valid_i,
   input  logic [FLOOR_W-1:0]    call_floor_i,
   input  logic [FLOOR_W-1:0]    current_floor_i,
   input  logic                  door_state_i,
   input  logic                  elevator_direction_i,
   output logic [FLOOR_W-1:0]    target_o,
   output logic                  pressed_o,
   output logic [NUM_FLOORS-1:0] pending_o,
   output logic                  busy_o
);

   localparam logic DOOR_OPEN = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam int   CNT_W     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_DWELL      = 3'd1,
      S_ISSUE      = 3'd2,
      S_WAIT_CLOSE = 3'd3,
      S_TRAVEL     = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [FLOOR_W-1:0]    target_q, target_d;
   logic                  scan_dir_q, scan_dir_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  call_blocked;
   logic                  arrive;
   logic [NUM_FLOORS-1:0] call_bit, here_bit, sel_src, above, below;
   logic [FLOOR_W-1:0]    above_lo, below_hi, sel_floor;
   logic                  sel_dir, sel_valid;

   // The car only monitors its own direction; the scheduler keeps its own sweep state.
   logic unused_direction;
   assign unused_direction = elevator_direction_i;

   assign call_blocked = (call_floor_i == current_floor_i) &&
                         ((state_q == S_IDLE) || (state_q == S_DWELL));
   assign arrive       = (state_q == S_TRAVEL) && (door_state_i == DOOR_OPEN);

   always_comb begin
      call_bit = '0;
      here_bit = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (call_valid_i && !call_blocked && (call_floor_i == FLOOR_W'(i)))
            call_bit[i] = 1'b1;
         if (current_floor_i == FLOOR_W'(i))
            here_bit[i] = 1'b1;
      end
   end

   // Arrival clear wins over a same-cycle call for the floor being served.
   assign pending_d = (pending_q | call_bit) & ~(arrive ? here_bit : '0);

   // A call landing this cycle already takes part in the DWELL selection.
   assign sel_src = pending_q | call_bit;

   always_comb begin
      above    = '0;
      below    = '0;
      above_lo = '0;
      below_hi = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) > current_floor_i) above[i] = sel_src[i];
         if (FLOOR_W'(i) < current_floor_i) below[i] = sel_src[i];
      end
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (above[i]) above_lo = FLOOR_W'(i);
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (below[i]) below_hi = FLOOR_W'(i);
      end
   end

   always_comb begin
      sel_floor = current_floor_i;
      sel_dir   = scan_dir_q;
      sel_valid = (above != '0) || (below != '0);
      if (scan_dir_q == DIR_UP) begin
         if (above != '0) begin
            sel_floor = above_lo;
            sel_dir   = DIR_UP;
         end else if (below != '0) begin
            sel_floor = below_hi;
            sel_dir   = DIR_DOWN;
         end
      end else begin
         if (below != '0) begin
            sel_floor = below_hi;
            sel_dir   = DIR_DOWN;
         end else if (above != '0) begin
            sel_floor = above_lo;
            sel_dir   = DIR_UP;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      target_d   = target_q;
      scan_dir_d = scan_dir_q;
      unique case (state_q)
         S_IDLE: begin
            if (pending_q != '0) begin
               state_d = S_DWELL;
               cnt_d   = CNT_RELOAD;
            end
         end
         S_DWELL: begin
            if (cnt_q == '0) begin
               // Nothing left to serve away from this floor: fall back to IDLE.
               if (sel_valid) begin
                  state_d    = S_ISSUE;
                  target_d   = sel_floor;
                  scan_dir_d = sel_dir;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_CLOSE;
         end
         S_WAIT_CLOSE: begin
            if (door_state_i != DOOR_OPEN) state_d = S_TRAVEL;
         end
         S_TRAVEL: begin
            if (arrive) begin
               if (pending_d != '0) begin
                  state_d = S_DWELL;
                  cnt_d   = CNT_RELOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         target_q   <= '0;
         scan_dir_q <= DIR_UP;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         target_q   <= target_d;
         scan_dir_q <= scan_dir_d;
         cnt_q      <= cnt_d;
      end
   end

   assign target_o  = target_q;
   assign pressed_o = (state_q == S_ISSUE);
   assign pending_o = pending_q;
   assign busy_o    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hax_call_scheduler.sv
`timescale 1ns/1ps
module tb_hax_call_scheduler;
   localparam int NF   = 8;
   localparam int D    = 4;
   localparam int FW   = 4;
   localparam int MOVE = 3;
   localparam int TMO  = 400;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          call_valid = 1'b0;
   logic [FW-1:0] call_floor = '0;
   logic [FW-1:0] cur_floor = '0;
   logic          door = 1'b1;
   logic          edir = 1'b1;
   logic [FW-1:0] target;
   logic          pressed;
   logic [NF-1:0] pending;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Elevator plant: closes the cycle after a press, one floor per MOVE cycles, opens on arrival.
   logic [FW-1:0] home_floor = '0;
   logic [FW-1:0] dest = '0;
   bit            close_next = 0;
   bit            moving = 0;
   int            tick = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst_n) begin
         cur_floor  = home_floor;
         door       = 1'b1;
         close_next = 0;
         moving     = 0;
         tick       = 0;
      end else if (pressed) begin
         close_next = 1;
         dest       = target;
         edir       = (target > cur_floor);
      end else if (close_next) begin
         close_next = 0;
         door       = 1'b0;
         moving     = 1;
         tick       = 0;
      end else if (moving) begin
         tick++;
         if (tick == MOVE) begin
            tick = 0;
            if (cur_floor < dest) cur_floor = cur_floor + 1'b1;
            else if (cur_floor > dest) cur_floor = cur_floor - 1'b1;
            if (cur_floor == dest) begin
               door   = 1'b1;
               moving = 0;
            end
         end
      end
   end

   hax_call_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(D), .FLOOR_W(FW)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .call_valid_i         (call_valid),
      .call_floor_i         (call_floor),
      .current_floor_i      (cur_floor),
      .door_state_i         (door),
      .elevator_direction_i (edir),
      .target_o             (target),
      .pressed_o            (pressed),
      .pending_o            (pending),
      .busy_o               (busy)
   );

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic call(input int f);
      call_valid = 1'b1;
      call_floor = FW'(f);
      step();
      call_valid = 1'b0;
   endtask

   task automatic do_reset(input int home);
      home_floor = FW'(home);
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_press(output bit got, output logic [FW-1:0] tgt,
                             output logic [NF-1:0] pend, output bit single);
      got = 0; tgt = '0; pend = '0; single = 0;
      for (int i = 0; i < TMO; i++) begin
         if (pressed === 1'b1) begin
            got  = 1;
            tgt  = target;
            pend = pending;
            step();
            single = (pressed === 1'b0);
            break;
         end
         step();
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < TMO; i++) begin
         if (busy === 1'b0 && door === 1'b1) begin
            ok = 1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      home_floor = '0;
      rst_n = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({target, pressed, pending, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: target=%0d pressed=%b pending=%h busy=%b, required all zero",
                  target, pressed, pending, busy);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (busy !== 1'b0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: busy=%b pressed=%b, required 0 0", busy, pressed);
      end
   endtask

   task automatic test_single_call();
      bit ok;
      call_valid = 1'b1;
      call_floor = FW'(7);
      for (int n = 1; n <= D + 2; n++) begin
         step();
         if (n == 1) begin
            call_valid = 1'b0;
            n_checks++;
            if (pending !== 8'h80) begin
               n_fail++;
               $display("FAIL single_pending_set: pending=%h, required 80", pending);
            end
         end
         if (n == D + 1) begin
            n_checks++;
            if (pressed !== 1'b0) begin
               n_fail++;
               $display("FAIL single_early_press: pressed=%b at c+%0d, required 0", pressed, n);
            end
         end
      end
      n_checks++;
      if (pressed !== 1'b1 || target !== FW'(7)) begin
         n_fail++;
         $display("FAIL single_latency: pressed=%b target=%0d at c+%0d, required 1 and 7",
                  pressed, target, D + 2);
      end
      step();
      n_checks++;
      if (pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pulse_width: pressed=%b one cycle later, required 0", pressed);
      end
      wait_idle(ok);
      n_checks++;
      if (!ok || pending !== '0 || cur_floor !== FW'(7)) begin
         n_fail++;
         $display("FAIL single_retire: idle=%b pending=%h floor=%0d, required 1 00 7",
                  ok, pending, cur_floor);
      end
   endtask

   task automatic test_scan_down();
      int            exp_t[3] = '{5, 2, 0};
      bit            got, single, ok;
      logic [FW-1:0] tgt;
      logic [NF-1:0] pend;
      call(2); call(5); call(0);
      foreach (exp_t[k]) begin
         wait_press(got, tgt, pend, single);
         n_checks++;
         if (!got || tgt !== FW'(exp_t[k]) || !single) begin
            n_fail++;
            $display("FAIL scan_down_%0d: got=%b target=%0d single=%b, required target %0d",
                     k, got, tgt, single, exp_t[k]);
         end
      end
      wait_idle(ok);
      n_checks++;
      if (!ok || pending !== '0) begin
         n_fail++;
         $display("FAIL scan_down_retire: idle=%b pending=%h, required 1 00", ok, pending);
      end
   endtask

   task automatic test_scan_inject();
      int            exp_t[3] = '{6, 3, 1};
      bit            got, single, ok;
      logic [FW-1:0] tgt;
      logic [NF-1:0] pend;
      do_reset(4);
      call(1); call(6);
      foreach (exp_t[k]) begin
         wait_press(got, tgt, pend, single);
         n_checks++;
         if (!got || tgt !== FW'(exp_t[k])) begin
            n_fail++;
            $display("FAIL scan_inject_%0d: got=%b target=%0d, required %0d", k, got, tgt, exp_t[k]);
         end
         if (k == 0) begin
            repeat (3) step();
            call(3);
         end
      end
      wait_idle(ok);
      n_checks++;
      if (!ok || pending !== '0 || cur_floor !== FW'(1)) begin
         n_fail++;
         $display("FAIL scan_inject_retire: idle=%b pending=%h floor=%0d, required 1 00 1",
                  ok, pending, cur_floor);
      end
   endtask

   task automatic test_ignored_calls();
      bit any_press = 0;
      call(1);
      n_checks++;
      if (pending !== '0) begin
         n_fail++;
         $display("FAIL ignore_current_floor: pending=%h, required 00", pending);
      end
      call(9);
      n_checks++;
      if (pending !== '0) begin
         n_fail++;
         $display("FAIL ignore_out_of_range: pending=%h, required 00", pending);
      end
      repeat (2 * D + 8) begin
         if (pressed === 1'b1 || busy === 1'b1) any_press = 1;
         step();
      end
      n_checks++;
      if (any_press) begin
         n_fail++;
         $display("FAIL ignore_no_activity: press or busy seen=%b, required 0", any_press);
      end
   endtask

   task automatic test_clear_wins();
      bit            got, single, saw_closed = 0, injected = 0, quiet = 1;
      logic [FW-1:0] tgt;
      logic [NF-1:0] pend;
      call(5);
      wait_press(got, tgt, pend, single);
      for (int i = 0; i < TMO && !injected; i++) begin
         if (door === 1'b0) saw_closed = 1;
         if (saw_closed && door === 1'b1 && cur_floor === FW'(5)) begin
            call(5);
            injected = 1;
         end else begin
            step();
         end
      end
      n_checks++;
      if (!got || tgt !== FW'(5) || !injected || pending !== '0) begin
         n_fail++;
         $display("FAIL clear_wins: press=%b target=%0d injected=%b pending=%h, required 1 5 1 00",
                  got, tgt, injected, pending);
      end
      repeat (2 * D + 8) begin
         if (pressed === 1'b1) quiet = 0;
         step();
      end
      n_checks++;
      if (!quiet || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_wins_no_repress: quiet=%b busy=%b, required 1 0", quiet, busy);
      end
   endtask

   task automatic test_reset_mid_travel();
      bit            got, single, closed = 0, ok;
      logic [FW-1:0] tgt;
      logic [NF-1:0] pend;
      call(7);
      wait_press(got, tgt, pend, single);
      for (int i = 0; i < TMO && !closed; i++) begin
         if (door === 1'b0) closed = 1;
         else step();
      end
      call(0); call(2); call(5);
      n_checks++;
      if (pending !== 8'hA5 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL travel_pending: pending=%h busy=%b, required a5 1", pending, busy);
      end
      home_floor = FW'(4);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (pending !== '0 || pressed !== 1'b0 || busy !== 1'b0 || target !== '0) begin
         n_fail++;
         $display("FAIL async_reset: pending=%h pressed=%b busy=%b target=%0d, required all zero",
                  pending, pressed, busy, target);
      end
      repeat (3) step();
      rst_n = 1'b1;
      step();
      call(2); call(6);
      wait_press(got, tgt, pend, single);
      n_checks++;
      if (!got || tgt !== FW'(6)) begin
         n_fail++;
         $display("FAIL reset_scan_up: got=%b target=%0d, required 6", got, tgt);
      end
      wait_press(got, tgt, pend, single);
      n_checks++;
      if (!got || tgt !== FW'(2)) begin
         n_fail++;
         $display("FAIL reset_scan_second: got=%b target=%0d, required 2", got, tgt);
      end
      wait_idle(ok);
   endtask

   // Reference: a SCAN sweep over the call set, computed from floor ordering alone.
   task automatic test_random();
      int            m_floor, m_dir, k, f, prev;
      int            order[$];
      logic [NF-1:0] s;
      bit            got, single, ok, quiet;
      logic [FW-1:0] tgt;
      logic [NF-1:0] pend;
      m_floor = $urandom_range(0, NF - 1);
      m_dir   = 1;
      do_reset(m_floor);
      for (int r = 0; r < 10; r++) begin
         s = '0;
         order.delete();
         k = $urandom_range(1, 4);
         for (int j = 0; j < k; j++) begin
            f = $urandom_range(0, NF + 1);
            if (f < NF && f != m_floor) s[f] = 1'b1;
            call(f);
         end
         if (m_dir == 1) begin
            for (int x = m_floor + 1; x < NF; x++) if (s[x]) order.push_back(x);
            for (int x = m_floor - 1; x >= 0; x--) if (s[x]) order.push_back(x);
         end else begin
            for (int x = m_floor - 1; x >= 0; x--) if (s[x]) order.push_back(x);
            for (int x = m_floor + 1; x < NF; x++) if (s[x]) order.push_back(x);
         end
         if (order.size() == 0) begin
            quiet = 1;
            repeat (2 * D + 6) begin
               if (pressed === 1'b1 || busy === 1'b1) quiet = 0;
               step();
            end
            n_checks++;
            if (!quiet || pending !== '0) begin
               n_fail++;
               $display("FAIL rand_r%0d_empty: quiet=%b pending=%h, required 1 00", r, quiet, pending);
            end
            continue;
         end
         prev = m_floor;
         foreach (order[i]) begin
            wait_press(got, tgt, pend, single);
            n_checks++;
            if (!got || tgt !== FW'(order[i]) || !single || (i == 0 && pend !== s)) begin
               n_fail++;
               $display("FAIL rand_r%0d_p%0d: got=%b target=%0d single=%b pending=%h, required target %0d pending %h",
                        r, i, got, tgt, single, pend, order[i], s);
            end
            m_dir = (order[i] > prev) ? 1 : 0;
            prev  = order[i];
         end
         m_floor = prev;
         wait_idle(ok);
         n_checks++;
         if (!ok || pending !== '0 || cur_floor !== FW'(m_floor)) begin
            n_fail++;
            $display("FAIL rand_r%0d_retire: idle=%b pending=%h floor=%0d, required 1 00 %0d",
                     r, ok, pending, cur_floor, m_floor);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_scan_down();
      test_scan_inject();
      test_ignored_calls();
      test_clear_wins();
      test_reset_mid_travel();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
